// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main controller.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package mips_ctrl_pkg;

    // Opcode field values, taken from IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BEQ    = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    // ALUOp encodings, consumed by ALU control
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // PCSource encodings
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Control vector driven by the state decoder
    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic       instrDone;
    } ctrl_t;

    function automatic logic isLegalOp(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_ADDI)  || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_ctrl_outputs.sv
// Combinational decode of FSM state (+ memory ready) into the control vector.
// Latency: zero cycles, purely combinational.
// Backpressure: memReady only gates the strobes that complete a memory access.
// Ports: state (current FSM state), memReady (effective ready), ctrl (control vector).
module mc_ctrl_outputs
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   memReady,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.memRead  = 1'b1;
                ctrl.aluSrcB  = SRCB_FOUR;
                ctrl.aluOp    = ALUOP_ADD;
                ctrl.pcSource = PCSRC_ALU;
                // IR and PC+4 are only committed once the fetch data is valid
                ctrl.irWrite  = memReady;
                ctrl.pcWrite  = memReady;
            end
            S_DECODE: begin
                // Branch target precomputed speculatively into ALUOut
                ctrl.aluSrcB = SRCB_IMMSH2;
                ctrl.aluOp   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.memtoReg  = 1'b1;
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            S_MEMWR: begin
                ctrl.memWrite  = 1'b1;
                ctrl.iorD      = 1'b1;
                ctrl.instrDone = memReady;
            end
            S_EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_B;
                ctrl.aluOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regDst    = 1'b1;
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            S_BEQ: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluSrcB     = SRCB_B;
                ctrl.aluOp       = ALUOP_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = PCSRC_ALUOUT;
                ctrl.instrDone   = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcWrite   = 1'b1;
                ctrl.pcSource  = PCSRC_JUMP;
                ctrl.instrDone = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/mem/writeback.
// Latency: 3 (BEQ, J) to 5 (LW) cycles per instruction with no memory wait states.
// Backpressure: FETCH, MEMRD and MEMWR hold one extra cycle per mem_ready-low cycle.
// Ports: clk, reset_n (async active-low), Opcode (IR[31:26]), mem_ready, datapath
//        control strobes, instr_done / illegal_op pulses, state_o (debug state).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] Opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t state;
    state_t stateNext;
    ctrl_t  ctrl;
    logic   memReady;

    // Without a handshake the memory is assumed single-cycle
    assign memReady = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // Reset forces START, whose decode is all-zero, so outputs drop immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_START;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = S_FETCH;
        case (state)
            S_START:  stateNext = S_FETCH;
            S_FETCH:  stateNext = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:     stateNext = S_EXEC;
                    OP_LW, OP_SW: stateNext = S_MEMADR;
                    OP_BEQ:       stateNext = S_BEQ;
                    OP_ADDI:      stateNext = S_ADDIEX;
                    OP_J:         stateNext = S_JUMP;
                    default:      stateNext = S_FETCH;
                endcase
            end
            S_MEMADR: stateNext = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  stateNext = memReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:  stateNext = memReady ? S_FETCH : S_MEMWR;
            S_EXEC:   stateNext = S_ALUWB;
            S_ADDIEX: stateNext = S_ADDIWB;
            // Writeback/retire states and unused encodings all return to FETCH
            default:  stateNext = S_FETCH;
        endcase
    end

    mc_ctrl_outputs uOutputs (
        .state    (state),
        .memReady (memReady),
        .ctrl     (ctrl)
    );

    assign PCWrite     = ctrl.pcWrite;
    assign PCWriteCond = ctrl.pcWriteCond;
    assign IorD        = ctrl.iorD;
    assign MemRead     = ctrl.memRead;
    assign MemWrite    = ctrl.memWrite;
    assign IRWrite     = ctrl.irWrite;
    assign MemtoReg    = ctrl.memtoReg;
    assign RegDst      = ctrl.regDst;
    assign RegWrite    = ctrl.regWrite;
    assign ALUSrcA     = ctrl.aluSrcA;
    assign ALUSrcB     = ctrl.aluSrcB;
    assign ALUOp       = ctrl.aluOp;
    assign PCSource    = ctrl.pcSource;
    assign instr_done  = ctrl.instrDone;
    assign illegal_op  = (state == S_DECODE) && !isLegalOp(Opcode);
    assign state_o     = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: scripted instruction stream with a scoreboard.
// Latency: expected state/control pushed when inputs are driven, compared mid-cycle.
// Backpressure: mem_ready wait states are scripted per instruction.
module tb_mips_multicycle_ctrl;

    localparam int ST_START = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3,
                   ST_MEMRD = 4, ST_MEMWB = 5, ST_MEMWR = 6, ST_EXEC = 7,
                   ST_ALUWB = 8, ST_BEQ = 9, ST_ADDIEX = 10, ST_ADDIWB = 11,
                   ST_JUMP = 12;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] Opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       instr_done, illegal_op;
    logic [3:0] state_o;

    typedef struct {
        int         st;
        logic       mr;
        logic [5:0] op;
    } exp_t;

    exp_t sbQ[$];
    int   nCompared = 0;
    int   nMismatch = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_HANDSHAKE(1'b1)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .Opcode      (Opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .state_o     (state_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst
    //            RegWrite ALUSrcA ALUSrcB[2] ALUOp[2] PCSource[2] instr_done illegal_op
    function automatic logic [17:0] expCtrl(input int st, input logic mr, input logic [5:0] op);
        logic pcW = 0, pcWC = 0, iorD = 0, mRd = 0, mWr = 0, irW = 0, m2r = 0, rDst = 0;
        logic rW = 0, srcA = 0, done = 0, ill = 0;
        logic [1:0] srcB = 2'b00, aOp = 2'b00, pcSrc = 2'b00;
        case (st)
            ST_FETCH:  begin mRd = 1; srcB = 2'b01; irW = mr; pcW = mr; end
            ST_DECODE: begin
                srcB = 2'b11;
                ill = !(op == 6'd0 || op == 6'd2 || op == 6'd4 || op == 6'd8 ||
                        op == 6'd35 || op == 6'd43);
            end
            ST_MEMADR: begin srcA = 1; srcB = 2'b10; end
            ST_MEMRD:  begin mRd = 1; iorD = 1; end
            ST_MEMWB:  begin m2r = 1; rW = 1; done = 1; end
            ST_MEMWR:  begin mWr = 1; iorD = 1; done = mr; end
            ST_EXEC:   begin srcA = 1; aOp = 2'b10; end
            ST_ALUWB:  begin rDst = 1; rW = 1; done = 1; end
            ST_BEQ:    begin srcA = 1; aOp = 2'b01; pcWC = 1; pcSrc = 2'b01; done = 1; end
            ST_ADDIEX: begin srcA = 1; srcB = 2'b10; end
            ST_ADDIWB: begin rW = 1; done = 1; end
            ST_JUMP:   begin pcW = 1; pcSrc = 2'b10; done = 1; end
            default: ;
        endcase
        return {pcW, pcWC, iorD, mRd, mWr, irW, m2r, rDst, rW, srcA, srcB, aOp, pcSrc, done, ill};
    endfunction

    // Scoreboard consumer: compares the DUT mid-cycle against the oldest expectation
    always @(negedge clk) begin
        if (sbQ.size() > 0) begin
            exp_t e;
            e = sbQ.pop_front();
            chk("state", {28'd0, state_o}, e.st);
            chk($sformatf("ctrl_st%0d", e.st),
                {14'd0, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op},
                {14'd0, expCtrl(e.st, e.mr, e.op)});
            chk("memRdWrExcl", {31'd0, MemRead & MemWrite}, 32'd0);
            chk("pcWrExcl", {31'd0, PCWrite & PCWriteCond}, 32'd0);
        end
    end

    task automatic step(input logic rst, input logic mr, input logic [5:0] op, input int st);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n   = rst;
        mem_ready = mr;
        Opcode    = op;
        e.st = st;
        e.mr = mr;
        e.op = op;
        sbQ.push_back(e);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Scripted expected state sequence of one instruction, from the first FETCH
    task automatic runInstr(input logic [5:0] op, input int fetchWaits, input int memWaits);
        for (int i = 0; i < fetchWaits; i++) step(1, 0, op, ST_FETCH);
        step(1, 1, op, ST_FETCH);
        step(1, rnd(), op, ST_DECODE);
        case (op)
            6'd35: begin
                step(1, rnd(), op, ST_MEMADR);
                for (int i = 0; i < memWaits; i++) step(1, 0, op, ST_MEMRD);
                step(1, 1, op, ST_MEMRD);
                step(1, rnd(), op, ST_MEMWB);
            end
            6'd43: begin
                step(1, rnd(), op, ST_MEMADR);
                for (int i = 0; i < memWaits; i++) step(1, 0, op, ST_MEMWR);
                step(1, 1, op, ST_MEMWR);
            end
            6'd0: begin
                step(1, rnd(), op, ST_EXEC);
                step(1, rnd(), op, ST_ALUWB);
            end
            6'd4: step(1, rnd(), op, ST_BEQ);
            6'd8: begin
                step(1, rnd(), op, ST_ADDIEX);
                step(1, rnd(), op, ST_ADDIWB);
            end
            6'd2: step(1, rnd(), op, ST_JUMP);
            default: ;
        endcase
    endtask

    initial begin
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        Opcode    = 6'd0;

        // Reset held, then exactly one START cycle after release
        for (int i = 0; i < 3; i++) step(0, 1, 6'd0, ST_START);
        step(1, 1, 6'd0, ST_START);

        runInstr(6'd35, 0, 0);          // LW, no waits
        runInstr(6'd43, 0, 3);          // SW, 3 wait cycles in MEMWR
        runInstr(6'd0, 0, 0);           // R-type
        runInstr(6'd4, 0, 0);           // BEQ
        runInstr(6'd2, 0, 0);           // J
        runInstr(6'd8, 0, 0);           // ADDI
        runInstr(6'd63, 0, 0);          // unsupported opcode
        runInstr(6'd0, 2, 0);           // FETCH stalled 2 cycles
        runInstr(6'd35, 1, 2);          // LW with fetch and read stalls

        // Asynchronous reset in the middle of a write
        step(1, 1, 6'd43, ST_FETCH);
        step(1, rnd(), 6'd43, ST_DECODE);
        step(1, rnd(), 6'd43, ST_MEMADR);
        step(1, 0, 6'd43, ST_MEMWR);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arstMemWrite", {31'd0, MemWrite}, 32'd0);
        chk("arstState", {28'd0, state_o}, ST_START);
        step(0, 1, 6'd0, ST_START);
        step(1, 1, 6'd0, ST_START);
        runInstr(6'd8, 0, 0);
        runInstr(6'd2, 0, 0);

        @(negedge clk);
        #1;
        chk("sbDrained", sbQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
